// File: rtl/calc_seq.sv
// calc_seq: runs a small command program against the queue calculator, one command at a time.
// Optional feature macro CALC_SEQ_CLR_EN: pulse calc_rst once before the first command of every run.
module calc_seq #(
  parameter int PUSH_CODE  = 0,
  parameter int POP_CODE   = 1,
  parameter int ADD_CODE   = 2,
  parameter int MULL_CODE  = 3,
  parameter int SUB_CODE   = 4,
  parameter int DIV_CODE   = 5,
  parameter int REM_CODE   = 6,
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [10:0]       prog_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  output logic [7:0]        calc_in,
  output logic [2:0]        calc_op,
  output logic              calc_apply,
  output logic              calc_rst,
  input  logic [7:0]        calc_tail,
  input  logic              calc_empty,
  input  logic              calc_valid,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_pc,
  output logic [7:0]        result,
  output logic              result_vld
);

  // Opcodes are forwarded opaquely; only their encodability is checked here.
  if (PROG_DEPTH != (1 << ADDR_W) || PUSH_CODE > 7 || POP_CODE > 7 || ADD_CODE > 7 ||
      MULL_CODE > 7 || SUB_CODE > 7 || DIV_CODE > 7 || REM_CODE > 7) begin : g_param_chk
    $error("calc_seq: inconsistent parameters");
  end

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_ISSUE, S_CHECK, S_FIN, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, err_pc_q, err_pc_d;
  logic [ADDR_W:0]   last_q, last_d;
  logic              zero_run_q, zero_run_d;
  logic [7:0]        in_q, in_d, result_q, result_d;
  logic [2:0]        op_q, op_d;
  logic              apply_q, apply_d, busy_q, busy_d;
  logic              done_q, done_d, error_q, error_d, rvld_q, rvld_d;
  logic              crst_q, crst_d;
  logic [10:0]       mem_q [PROG_DEPTH];
  logic [10:0]       slot;

  assign slot = mem_q[pc_d];

  always_ff @(posedge clk) begin
    if (prog_we && !busy_q) mem_q[prog_addr] <= prog_data;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    err_pc_d   = err_pc_q;
    last_d     = last_q;
    zero_run_d = zero_run_q;
    result_d   = result_q;
    done_d     = done_q;
    error_d    = error_q;
    rvld_d     = rvld_q;
    in_d       = in_q;
    op_d       = op_q;
    case (state_q)
      S_IDLE: if (start) begin
        done_d  = 1'b0;
        error_d = 1'b0;
        rvld_d  = 1'b0;
        if (prog_len == '0) begin
          zero_run_d = 1'b1;
          state_d    = S_FIN;
        end else begin
          zero_run_d = 1'b0;
          last_d     = prog_len - (ADDR_W+1)'(1);
          pc_d       = '0;
`ifdef CALC_SEQ_CLR_EN
          state_d    = S_CLR;
`else
          state_d    = S_ISSUE;
`endif
        end
      end
      S_CLR:   state_d = S_ISSUE;
      S_ISSUE: state_d = S_CHECK;
      S_CHECK: begin
        if (!calc_valid) begin
          err_pc_d = pc_q;
          state_d  = S_ERR;
        end else if ({1'b0, pc_q} == last_q) begin
          state_d = S_FIN;
        end else begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_FIN: begin
        if (zero_run_q) begin
          rvld_d = 1'b0;
        end else begin
          result_d = calc_tail;
          rvld_d   = !calc_empty;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        error_d = 1'b1;
        rvld_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Strobes are decoded from the next state so they line up with the state itself.
    busy_d  = (state_d != S_IDLE);
    apply_d = (state_d == S_ISSUE);
    crst_d  = (state_d == S_CLR);
    if (state_d == S_ISSUE) begin
      op_d = slot[10:8];
      in_d = slot[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      err_pc_q   <= '0;
      last_q     <= '0;
      zero_run_q <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rvld_q     <= 1'b0;
      in_q       <= '0;
      op_q       <= '0;
      apply_q    <= 1'b0;
      busy_q     <= 1'b0;
      crst_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      err_pc_q   <= err_pc_d;
      last_q     <= last_d;
      zero_run_q <= zero_run_d;
      result_q   <= result_d;
      done_q     <= done_d;
      error_q    <= error_d;
      rvld_q     <= rvld_d;
      in_q       <= in_d;
      op_q       <= op_d;
      apply_q    <= apply_d;
      busy_q     <= busy_d;
      crst_q     <= crst_d;
    end
  end

  assign calc_in    = in_q;
  assign calc_op    = op_q;
  assign calc_apply = apply_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_pc     = err_pc_q;
  assign result     = result_q;
  assign result_vld = rvld_q;
`ifdef CALC_SEQ_CLR_EN
  assign calc_rst   = crst_q;
`else
  assign calc_rst   = 1'b0;
`endif

endmodule

// File: tb/tb_calc_seq.sv
// Bench for calc_seq: behavioural stack calculator on the far side, table of programs plus
// hand-written sequences for busy-time writes/starts and a mid-run reset.
module tb_calc_seq;

`ifdef CALC_SEQ_CLR_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [10:0] prog_data = '0;
  logic [4:0] prog_len = '0;
  logic       start = 1'b0;
  logic [7:0] calc_in;
  logic [2:0] calc_op;
  logic       calc_apply, calc_rst;
  logic [7:0] calc_tail = '0;
  logic       calc_empty = 1'b1;
  logic       calc_valid = 1'b1;
  logic       busy, done, error, result_vld;
  logic [3:0] err_pc;
  logic [7:0] result;
  logic       tb_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  calc_seq dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_len(prog_len), .start(start), .calc_in(calc_in), .calc_op(calc_op),
    .calc_apply(calc_apply), .calc_rst(calc_rst), .calc_tail(calc_tail),
    .calc_empty(calc_empty), .calc_valid(calc_valid), .busy(busy), .done(done),
    .error(error), .err_pc(err_pc), .result(result), .result_vld(result_vld)
  );

  always #5 clk = ~clk;

  // Calculator model: stack, tail = top; binary ops combine second-from-top with top.
  logic [7:0] mq[$];
  logic [7:0] ma, mb, mr;
  logic       mok;
  always @(posedge clk) begin
    if (tb_clr || calc_rst) begin
      mq.delete();
      calc_valid <= 1'b1;
      calc_tail  <= 8'd0;
      calc_empty <= 1'b1;
    end else if (calc_apply) begin
      mok = 1'b1;
      case (calc_op)
        3'd0: mq.push_back(calc_in);
        3'd1: if (mq.size() > 0) ma = mq.pop_back(); else mok = 1'b0;
        3'd2, 3'd3, 3'd4, 3'd5, 3'd6: begin
          if (mq.size() < 2) mok = 1'b0;
          else if ((calc_op == 3'd5 || calc_op == 3'd6) && mq[mq.size()-1] == 8'd0) mok = 1'b0;
          else begin
            mb = mq.pop_back();
            ma = mq.pop_back();
            case (calc_op)
              3'd2:    mr = ma + mb;
              3'd3:    mr = ma * mb;
              3'd4:    mr = ma - mb;
              3'd5:    mr = ma / mb;
              default: mr = ma % mb;
            endcase
            mq.push_back(mr);
          end
        end
        default: mok = 1'b0;
      endcase
      calc_valid <= mok;
      calc_tail  <= (mq.size() > 0) ? mq[mq.size()-1] : 8'd0;
      calc_empty <= (mq.size() == 0);
    end
  end

  typedef struct {
    logic [4:0][10:0] prog;
    int n;
    int len;
    bit exp_done;
    bit exp_err;
    int exp_err_pc;
    int exp_result;
    bit exp_rv;
    int exp_applies;
    int exp_lastop;
    int exp_first_in;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [10:0] cmd(input int op, input int v);
    logic [10:0] c;
    c = {op[2:0], v[7:0]};
    return c;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_prog(input vec_t v, input string nm, input int poke);
    int cyc, apps, crs, lastop, first_in, exp_cyc;
    bit spacing_bad, busy1;
    for (int k = 0; k < v.n; k++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = k[3:0]; prog_data = v.prog[k];
    end
    @(negedge clk);
    prog_we = 1'b0; tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0; prog_len = v.len[4:0]; start = 1'b1;
    cyc = 0; apps = 0; crs = 0; lastop = -1; first_in = -1; spacing_bad = 0; busy1 = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; prog_we = 1'b0;
      if (cyc == poke) begin
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = cmd(0, 99); start = 1'b1; prog_len = 5'd1;
      end
      if (cyc == 1) busy1 = busy;
      if (calc_rst) crs++;
      if (calc_apply) begin
        if (apps == 0) first_in = calc_in;
        if (cyc != CLR + 1 + 2*apps) spacing_bad = 1;
        apps++;
        lastop = calc_op;
      end
      if (done || error) break;
    end
    start = 1'b0; prog_we = 1'b0;
    if (v.len == 0) exp_cyc = 2;
    else if (v.exp_err) exp_cyc = 2*(v.exp_err_pc + 1) + 2 + CLR;
    else exp_cyc = 2*v.len + 2 + CLR;
    chk({nm, " finish cycle"}, cyc, exp_cyc);
    chk({nm, " busy after start"}, busy1, 1);
    chk({nm, " busy at end"}, busy, 0);
    chk({nm, " done"}, done, v.exp_done);
    chk({nm, " error"}, error, v.exp_err);
    if (v.exp_err) chk({nm, " err_pc"}, err_pc, v.exp_err_pc);
    chk({nm, " result"}, result, v.exp_result);
    chk({nm, " result_vld"}, result_vld, v.exp_rv);
    chk({nm, " apply pulses"}, apps, v.exp_applies);
    chk({nm, " apply spacing"}, spacing_bad, 0);
    chk({nm, " calc_rst pulses"}, crs, (v.len == 0) ? 0 : CLR);
    if (v.exp_applies > 0) begin
      chk({nm, " last op"}, lastop, v.exp_lastop);
      chk({nm, " first operand"}, first_in, v.exp_first_in);
    end
  endtask

  function automatic vec_t mk(input int len, input bit d, input bit e, input int epc,
                              input int res, input bit rv, input int apps, input int lop,
                              input int fin);
    vec_t v;
    v.prog = '0; v.n = 0; v.len = len; v.exp_done = d; v.exp_err = e; v.exp_err_pc = epc;
    v.exp_result = res; v.exp_rv = rv; v.exp_applies = apps; v.exp_lastop = lop;
    v.exp_first_in = fin;
    return v;
  endfunction

  initial begin
    vec_t v;
    // push 5, push 7, add -> 12
    v = mk(3, 1, 0, 0, 12, 1, 3, 2, 5);
    v.prog[0] = cmd(0, 5); v.prog[1] = cmd(0, 7); v.prog[2] = cmd(2, 0); v.n = 3;
    vecs.push_back(v);
    // divide by zero at slot 2; push 9 never issued; result keeps 12
    v = mk(4, 0, 1, 2, 12, 0, 3, 5, 1);
    v.prog[0] = cmd(0, 1); v.prog[1] = cmd(0, 0); v.prog[2] = cmd(5, 0); v.prog[3] = cmd(0, 9);
    v.n = 4;
    vecs.push_back(v);
    // underflow on first add
    v = mk(4, 0, 1, 1, 12, 0, 2, 2, 1);
    v.prog[0] = cmd(0, 1); v.prog[1] = cmd(2, 0); v.prog[2] = cmd(2, 0); v.prog[3] = cmd(2, 0);
    v.n = 4;
    vecs.push_back(v);
    // empty program: done on cycle 2, result untouched
    v = mk(0, 1, 0, 0, 12, 0, 0, 0, 0);
    vecs.push_back(v);
    // (3*4) - 10 = 2
    v = mk(5, 1, 0, 0, 2, 1, 5, 4, 3);
    v.prog[0] = cmd(0, 3); v.prog[1] = cmd(0, 4); v.prog[2] = cmd(3, 0); v.prog[3] = cmd(0, 10);
    v.prog[4] = cmd(4, 0); v.n = 5;
    vecs.push_back(v);
    // 17 % 5 then pop: queue empty at end, tail reads 0
    v = mk(4, 1, 0, 0, 0, 0, 4, 1, 17);
    v.prog[0] = cmd(0, 17); v.prog[1] = cmd(0, 5); v.prog[2] = cmd(6, 0); v.prog[3] = cmd(1, 0);
    v.n = 4;
    vecs.push_back(v);
    // opcode 7 goes out unchanged and the calculator rejects it
    v = mk(2, 0, 1, 1, 0, 0, 2, 7, 1);
    v.prog[0] = cmd(0, 1); v.prog[1] = cmd(7, 0); v.n = 2;
    vecs.push_back(v);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset error", error, 0);
    chk("reset apply", calc_apply, 0);
    chk("reset calc_rst", calc_rst, 0);
    chk("reset outs", {calc_in, calc_op, err_pc, result, result_vld}, 0);

    foreach (vecs[i]) run_prog(vecs[i], $sformatf("vec%0d", i), -1);

    // prog_we and start while busy are both dropped
    run_prog(vecs[0], "busy_poke", 2);
    v = vecs[0]; v.n = 0;
    run_prog(v, "after_poke", -1);

    // synchronous reset during CHECK of slot 1
    begin
      int cyc, apps;
      @(negedge clk); tb_clr = 1'b1;
      @(negedge clk); tb_clr = 1'b0; prog_len = 5'd3; start = 1'b1;
      cyc = 0; apps = 0;
      while (cyc < 4) begin
        @(negedge clk);
        cyc++;
        start = 1'b0;
        if (calc_apply) apps++;
      end
      chk("pre-rst applies", apps, 2);
      chk("pre-rst busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid-rst busy", busy, 0);
      chk("mid-rst apply", calc_apply, 0);
      chk("mid-rst done", done, 0);
      chk("mid-rst error", error, 0);
      chk("mid-rst outs", {calc_in, calc_op, err_pc, result, result_vld, calc_rst}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post-rst done", done, 0);
      chk("post-rst error", error, 0);
      run_prog(v, "rerun", -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
